// File: rtl/apb_pwm_multi.sv
// apb_pwm_multi: multi-channel PWM generator on an APB slave port.
// Each channel has its own period, duty, polarity and one-shot mode. Period
// and duty go through shadow registers that reload only at a period boundary,
// so an update never produces a runt or stretched pulse. Each channel sets its
// bit in INT_STS at the end of every period, and irq reports the enabled bits.
module apb_pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              apb_psel,
  input  logic [31:0]       apb_paddr,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [31:0]       apb_pwdata,
  output logic [31:0]       apb_prdata,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq
);

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic              w_wr_en;
  logic              w_rd_en;
  logic [7:0]        w_addr;
  logic [3:0]        w_page;
  logic [1:0]        w_reg;
  logic              w_word_ok;
  logic              w_sts_sel;
  logic              w_ien_sel;
  logic [NUM_CH-1:0] w_w1c;
  logic [NUM_CH-1:0] w_set;
  logic [31:0]       w_glob_rdata;
  logic [NUM_CH-1:0][31:0] w_ch_rdata;
  logic [31:0]       w_rdata;
  logic              w_unused;

  logic [NUM_CH-1:0] r_int_sts;
  logic [NUM_CH-1:0] r_int_en;

  assign w_wr_en   = apb_psel & apb_penable & apb_pwrite;
  assign w_rd_en   = apb_psel & apb_penable & ~apb_pwrite;
  assign w_addr    = apb_paddr[7:0];
  // Page 0 holds the global registers, page n+1 holds channel n.
  assign w_page    = w_addr[7:4];
  assign w_reg     = w_addr[3:2];
  assign w_word_ok = (w_addr[1:0] == 2'b00);
  assign w_sts_sel = (w_addr == 8'h00);
  assign w_ien_sel = (w_addr == 8'h04);

  // Only the low address byte is decoded; the remaining bus bits are ignored.
  assign w_unused = ^{apb_paddr[31:8], apb_pwdata};

  // Software clear mask for INT_STS: a 1 in the write data clears that bit.
  assign w_w1c = (w_wr_en && w_sts_sel) ? apb_pwdata[NUM_CH-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Global registers
  // ---------------------------------------------------------------------------
  // Interrupt status: hardware set takes priority over a simultaneous clear.
  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_int_sts <= '0;
    end else begin
      r_int_sts <= (r_int_sts & ~w_w1c) | w_set;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_int_en <= '0;
    end else if (w_wr_en && w_ien_sel) begin
      r_int_en <= apb_pwdata[NUM_CH-1:0];
    end
  end

  assign irq = |(r_int_sts & r_int_en);

  // Read data for the global page; zero outside a read access phase.
  always_comb begin
    w_glob_rdata = '0;
    if (w_rd_en) begin
      if (w_sts_sel) begin
        w_glob_rdata = 32'(r_int_sts);
      end else if (w_ien_sel) begin
        w_glob_rdata = 32'(r_int_en);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_period;
      logic [CNT_W-1:0] r_duty;
      logic [2:0]       r_ctrl;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_per_sh;
      logic [CNT_W-1:0] r_duty_sh;
      logic             r_pwm;

      logic             w_sel;
      logic             w_wr_per;
      logic             w_wr_duty;
      logic             w_wr_ctrl;
      logic             w_en;
      logic             w_pol;
      logic             w_oneshot;
      logic             w_run;
      logic             w_wrap;
      logic [31:0]      w_rd;

      assign w_sel     = w_word_ok && (w_page == 4'(gi + 1));
      assign w_wr_per  = w_wr_en && w_sel && (w_reg == 2'd0);
      assign w_wr_duty = w_wr_en && w_sel && (w_reg == 2'd1);
      assign w_wr_ctrl = w_wr_en && w_sel && (w_reg == 2'd2);

      assign w_en      = r_ctrl[0];
      assign w_pol     = r_ctrl[1];
      assign w_oneshot = r_ctrl[2];

      // Counting only happens with a non-zero shadow period; a zero period parks the channel.
      assign w_run  = w_en && (r_per_sh != '0);
      // cnt never exceeds per_sh-1, so per_sh-1 cannot underflow while running.
      assign w_wrap = w_run && (r_cnt >= (r_per_sh - 1'b1));

      assign w_set[gi] = w_wrap;
      assign pwm_o[gi] = r_pwm;

      // Software-visible configuration; a CTRL write beats the one-shot auto-clear.
      always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
          r_period <= '0;
          r_duty   <= '0;
          r_ctrl   <= '0;
        end else begin
          if (w_wr_per) begin
            r_period <= apb_pwdata[CNT_W-1:0];
          end
          if (w_wr_duty) begin
            r_duty <= apb_pwdata[CNT_W-1:0];
          end
          if (w_wr_ctrl) begin
            r_ctrl <= apb_pwdata[2:0];
          end else if (w_wrap && w_oneshot) begin
            r_ctrl[0] <= 1'b0;
          end
        end
      end

      // Counter, shadow reload and registered output pin.
      always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
          r_cnt     <= '0;
          r_per_sh  <= '0;
          r_duty_sh <= '0;
          r_pwm     <= 1'b0;
        end else if (!w_en) begin
          // Idle: shadows follow the programmed values so enable starts a clean period.
          r_cnt     <= '0;
          r_per_sh  <= r_period;
          r_duty_sh <= r_duty;
          r_pwm     <= w_pol;
        end else if (r_per_sh == '0) begin
          r_cnt <= '0;
          r_pwm <= w_pol;
        end else begin
          r_pwm <= (r_cnt < r_duty_sh) ^ w_pol;
          if (w_wrap) begin
            r_cnt     <= '0;
            r_per_sh  <= r_period;
            r_duty_sh <= r_duty;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // Channel read data, zero unless this channel's page is addressed in a read.
      always_comb begin
        w_rd = '0;
        if (w_rd_en && w_sel) begin
          case (w_reg)
            2'd0:    w_rd = 32'(r_period);
            2'd1:    w_rd = 32'(r_duty);
            2'd2:    w_rd = 32'(r_ctrl);
            default: w_rd = 32'(r_cnt);
          endcase
        end
      end

      assign w_ch_rdata[gi] = w_rd;
    end
  endgenerate

  // At most one source is non-zero, so the read mux reduces to an OR.
  always_comb begin
    w_rdata = w_glob_rdata;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rdata = w_rdata | w_ch_rdata[i];
    end
  end

  assign apb_prdata = w_rdata;

endmodule
